pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits, a multiple of GROUP, minimum 4.
REQ-002 The block SHALL have parameter GROUP, default 4, meaning bits per carry-lookahead group; one pipeline stage per group.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands and op presented this cycle.
REQ-006 in_ready  output  1  block accepts the operation when in_valid && in_ready.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in, ADD mode only.
REQ-009 op  input  1  0 = ADD (a+b+cin), 1 = SUB (a-b; cin ignored).
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer takes the result when out_valid && out_ready.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of MSB; in SUB, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 Per group: G = a&b, P = a^b (SUB uses ~b); carry into group bit 0 is the group carry-in, never a G term.
REQ-016 Group k carry-in: stage 0 uses cin (ADD) or 1 (SUB); group k>0 uses registered carry-out of group k-1.
REQ-017 Group k output: c[i+1] = G[i] | (P[i] & c[i]), full lookahead within the group; sum bit = P ^ c.
REQ-018 Pipeline depth N = WIDTH/GROUP; latency from accepted input to out_valid = N cycles with no stall.
REQ-019 Stage k computes group k and carries still-unprocessed operand bits, op and finished sum bits forward alongside its valid bit.
REQ-020 Advance condition adv = out_ready || !out_valid; all stages and valid bits shift only when adv = 1.
REQ-021 in_ready = adv, combinational; no combinational path from in_valid to in_ready.
REQ-022 When adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0; bubbles are not collapsed.
REQ-023 When adv = 0, all stage contents, sum, cout, ovf and out_valid hold unchanged.
REQ-024 Throughput: one operation per cycle with out_ready held high; results leave in acceptance order.
REQ-025 cout = carry out of bit WIDTH-1; ovf = carry into MSB XOR carry out of MSB.
REQ-026 Simultaneous accept at input and take at output in the same cycle SHALL lose no operation.
REQ-027 Output fields when out_valid = 0 are don't-care except immediately after reset (see REQ-029).

Reset
REQ-028 rst = 1 at a clock edge SHALL clear every stage valid bit and out_valid, discarding in-flight operations, including any accepted that same cycle.
REQ-029 On reset sum = 0, cout = 0, ovf = 0; in_ready = 1 in the first cycle after reset.
REQ-030 Datapath registers other than those in REQ-029 need no reset.

Structure
REQ-031 Shared package cla_pkg SHALL hold the op enum (OP_ADD = 0, OP_SUB = 1) and default constant CLA_GROUP = 4.
REQ-032 Sub-module cla_group (combinational, GROUP-bit: a, b, ci -> s, co, c_msb_in) SHALL be instantiated N times.
REQ-033 Elaboration SHALL fail if WIDTH % GROUP != 0.

Verification (WIDTH = 16, GROUP = 4, latency 4)
REQ-034 ADD 0xFFFF + 0x0001, cin = 0 -> after 4 cycles sum = 0x0000, cout = 1, ovf = 0.
REQ-035 ADD 0x0000 + 0x0000, cin = 1 -> sum = 0x0001, cout = 0; SUB 0x8000 - 0x0001 -> sum = 0x7FFF, cout = 1, ovf = 1.
REQ-036 Six back-to-back ops with out_ready low for cycles 3-5 -> in_ready low in those cycles, all six results exact and in order, none duplicated.
REQ-037 Assert rst in the cycle after the 2nd of 3 accepted ops -> out_valid never rises for them; sum/cout/ovf = 0; in_ready = 1 next cycle.
REQ-038 10k random ops (random op, cin, in_valid, out_ready) scored against a reference model of a+b+cin / a-b, including ovf.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: operation
// encoding, default group size and the stage-0 carry-in selection.
package cla_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   localparam int CLA_GROUP = 4;

   // Subtraction is a + ~b + 1, so the first group always sees a carry of 1.
   function automatic logic group_cin(input logic op, input logic cin);
      return (op_e'(op) == OP_SUB) ? 1'b1 : cin;
   endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice. Every carry is a flat sum of products
// of the group's generate/propagate terms and the group carry-in.
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = CLA_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             ci,
   output logic [GROUP-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // c[i+1] = ci&p[0..i] | g[0]&p[1..i] | ... | g[i], built without ripple
   always_comb begin
      logic term;
      term = 1'b0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < GROUP; i++) begin
         term = ci;
         for (int m = 0; m <= i; m++) begin
            term = term & p[m];
         end
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) begin
               term = term & p[m];
            end
            c[i+1] = c[i+1] | term;
         end
      end
   end

   assign s        = p ^ c[GROUP-1:0];
   assign co       = c[GROUP];
   assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one carry-lookahead group per stage, the
// group carry-out registered into the next stage, with valid/ready flow control.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = CLA_GROUP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N = WIDTH / GROUP;

   if ((WIDTH % GROUP) != 0 || WIDTH < 4) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be >= 4 and a multiple of GROUP");
   end

   logic             adv;
   logic [N-1:0]     valid_reg;
   logic [N-1:0]     carry_reg;
   logic             ovf_reg   [N];
   logic             op_reg    [N];
   logic [WIDTH-1:0] a_reg     [N];
   logic [WIDTH-1:0] b_reg     [N];
   logic [WIDTH-1:0] sum_reg   [N];

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign adv      = out_ready || !valid_reg[N-1];
   assign in_ready = adv;

   for (genvar gi = 0; gi < N; gi++) begin : g_stage
      logic             v_in;
      logic             op_in;
      logic             c_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic [WIDTH-1:0] s_next;
      logic [GROUP-1:0] grp_b;
      logic [GROUP-1:0] grp_s;
      logic             grp_co;
      logic             grp_cmsb;

      if (gi == 0) begin : g_head
         assign v_in  = in_valid;
         assign op_in = op;
         assign c_in  = group_cin(op, cin);
         assign a_in  = a;
         assign b_in  = b;
         assign s_in  = '0;
      end else begin : g_body
         assign v_in  = valid_reg[gi-1];
         assign op_in = op_reg[gi-1];
         assign c_in  = carry_reg[gi-1];
         assign a_in  = a_reg[gi-1];
         assign b_in  = b_reg[gi-1];
         assign s_in  = sum_reg[gi-1];
      end

      assign grp_b = b_in[gi*GROUP +: GROUP] ^ {GROUP{op_in}};

      cla_group #(
         .GROUP(GROUP)
      ) u_group (
         .a       (a_in[gi*GROUP +: GROUP]),
         .b       (grp_b),
         .ci      (c_in),
         .s       (grp_s),
         .co      (grp_co),
         .c_msb_in(grp_cmsb)
      );

      always_comb begin
         s_next                     = s_in;
         s_next[gi*GROUP +: GROUP]  = grp_s;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_reg[gi] <= 1'b0;
            carry_reg[gi] <= 1'b0;
            ovf_reg[gi]   <= 1'b0;
            sum_reg[gi]   <= '0;
         end else if (adv) begin
            valid_reg[gi] <= v_in;
            carry_reg[gi] <= grp_co;
            ovf_reg[gi]   <= grp_cmsb ^ grp_co;
            sum_reg[gi]   <= s_next;
         end
      end

      always_ff @(posedge clk) begin
         if (adv) begin
            op_reg[gi] <= op_in;
            a_reg[gi]  <= a_in;
            b_reg[gi]  <= b_in;
         end
      end
   end

   assign out_valid = valid_reg[N-1];
   assign sum       = sum_reg[N-1];
   assign cout      = carry_reg[N-1];
   assign ovf       = ovf_reg[N-1];

endmodule
